// File: rtl/rsa_pkg.sv
// Shared constants and FSM state type for the RSA decryption block.
package rsa_pkg;
  localparam int RSA_WIDTH  = 32;
  localparam int MUL_ITERS  = 32;
  localparam int ITER_CNT_W = $clog2(MUL_ITERS);
  localparam logic [ITER_CNT_W-1:0] ITER_LAST = ITER_CNT_W'(MUL_ITERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_MUL,
    ST_SQR,
    ST_DONE
  } rsa_state_e;
endpackage

// File: rtl/rsa_modmul_seq.sv
// Sequential interleaved modular multiplier: result = a*b mod n, operands < n.
// One start cycle latches the operands, then 32 MSB-first shift-add iterations.
module rsa_modmul_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic                  busy;
  logic [ITER_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [WIDTH-1:0]      n_q;
  logic [WIDTH-1:0]      r_q;
  logic [WIDTH+1:0]      n_ext;
  logic [WIDTH+1:0]      sum;
  logic [WIDTH+1:0]      sub1;

  // 2r + a < 3n, so two conditional subtractions bring r back below n.
  always_comb begin
    n_ext  = {2'b00, n_q};
    sum    = {1'b0, r_q, 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    sub1   = (sum >= n_ext) ? sum - n_ext : sum;
    result = WIDTH'((sub1 >= n_ext) ? sub1 - n_ext : sub1);
    done   = busy && (cnt == ITER_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      n_q  <= '0;
      r_q  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      a_q  <= a;
      b_q  <= b;
      n_q  <= n;
      r_q  <= '0;
    end else if (busy) begin
      r_q <= result;
      b_q <= b_q << 1;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_decrypt_sm.sv
// RSA decryption M = C^d mod n by right-to-left square-and-multiply.
// Optional RSA_DECRYPT_CONST_TIME_EN: fixed 32-bit exponent walk with uniform latency.
module rsa_decrypt_sm
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             compute,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] M,
  output logic             decrypt_done,
  output logic             decrypt_err,
  output rsa_state_e       state
);

  // Request protocol: compute is a level sampled only in IDLE; operands are
  // captured on that edge. decrypt_done stays high until compute is seen low,
  // and IDLE is re-entered on the following edge.

  rsa_state_e            state_next;
  logic [WIDTH-1:0]      c_q;
  logic [WIDTH-1:0]      e_q;
  logic [WIDTH-1:0]      n_q;
  logic [WIDTH-1:0]      base;
  logic [WIDTH-1:0]      acc;
  logic [ITER_CNT_W-1:0] cnt;
  logic                  mm_started;
  logic                  mm_start;
  logic [WIDTH-1:0]      mm_a;
  logic                  mm_done;
  logic [WIDTH-1:0]      mm_result;
  logic [WIDTH:0]        rem_shift;
  logic [WIDTH-1:0]      base_red;

  rsa_modmul_seq #(.WIDTH(WIDTH)) u_modmul (
    .clk    (clk),
    .reset  (reset),
    .start  (mm_start),
    .a      (mm_a),
    .b      (base),
    .n      (n_q),
    .done   (mm_done),
    .result (mm_result)
  );

  // Restoring division step; base doubles as the partial remainder in REDUCE.
  always_comb begin
    rem_shift = {base, c_q[WIDTH-1]};
    base_red  = WIDTH'((rem_shift >= {1'b0, n_q}) ? rem_shift - {1'b0, n_q} : rem_shift);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mm_start   = 1'b0;
    mm_a       = acc;
    case (state)
      ST_IDLE: begin
        if (compute) state_next = (n == '0) ? ST_DONE : ST_REDUCE;
      end
      ST_REDUCE: begin
        if (cnt == ITER_LAST) begin
`ifdef RSA_DECRYPT_CONST_TIME_EN
          state_next = ST_MUL;
`else
          if (e_q == '0)  state_next = ST_DONE;
          else if (e_q[0]) state_next = ST_MUL;
          else             state_next = ST_SQR;
`endif
        end
      end
      ST_MUL: begin
        mm_start = !mm_started;
        if (mm_done) begin
`ifdef RSA_DECRYPT_CONST_TIME_EN
          state_next = ST_SQR;
`else
          state_next = (e_q[WIDTH-1:1] == '0) ? ST_DONE : ST_SQR;
`endif
        end
      end
      ST_SQR: begin
        mm_start = !mm_started;
        mm_a     = base;
        if (mm_done) begin
`ifdef RSA_DECRYPT_CONST_TIME_EN
          state_next = (cnt == ITER_LAST) ? ST_DONE : ST_MUL;
`else
          if (e_q[WIDTH-1:1] == '0) state_next = ST_DONE;
          else if (e_q[1])          state_next = ST_MUL;
          else                      state_next = ST_SQR;
`endif
        end
      end
      ST_DONE: begin
        if (decrypt_done && !compute) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q          <= '0;
      e_q          <= '0;
      n_q          <= '0;
      base         <= '0;
      acc          <= '0;
      cnt          <= '0;
      mm_started   <= 1'b0;
      M            <= '0;
      decrypt_done <= 1'b0;
      decrypt_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (compute) begin
            c_q          <= C;
            e_q          <= d;
            n_q          <= n;
            base         <= '0;
            acc          <= '0;
            cnt          <= '0;
            mm_started   <= 1'b0;
            decrypt_done <= 1'b0;
            decrypt_err  <= 1'b0;
          end
        end
        ST_REDUCE: begin
          base <= base_red;
          c_q  <= c_q << 1;
          cnt  <= cnt + 1'b1;
          if (cnt == ITER_LAST)
            acc <= (n_q == {{(WIDTH-1){1'b0}}, 1'b1}) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
        end
        ST_MUL: begin
          if (mm_start) mm_started <= 1'b1;
          if (mm_done) begin
            mm_started <= 1'b0;
            // In constant-time mode the product is computed for a 0 bit but dropped.
            if (e_q[0]) acc <= mm_result;
          end
        end
        ST_SQR: begin
          if (mm_start) mm_started <= 1'b1;
          if (mm_done) begin
            mm_started <= 1'b0;
            base       <= mm_result;
            e_q        <= e_q >> 1;
            cnt        <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!decrypt_done) begin
            M            <= acc;
            decrypt_done <= 1'b1;
            decrypt_err  <= (n_q == '0);
          end else if (!compute) begin
            decrypt_done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt_sm.sv
// Self-checking bench for rsa_decrypt_sm: reference modexp model feeding an expected queue.
module tb_rsa_decrypt_sm;
  import rsa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        compute;
  logic [31:0] C;
  logic [31:0] d;
  logic [31:0] n;
  logic [31:0] M;
  logic        decrypt_done;
  logic        decrypt_err;
  rsa_state_e  state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  always #5 clk = ~clk;

  rsa_decrypt_sm #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .compute      (compute),
    .C            (C),
    .d            (d),
    .n            (n),
    .M            (M),
    .decrypt_done (decrypt_done),
    .decrypt_err  (decrypt_err),
    .state        (state)
  );

  function automatic logic [31:0] model_modexp(input logic [31:0] c_in, input logic [31:0] e_in,
                                              input logic [31:0] n_in);
    logic [63:0] b;
    logic [63:0] r;
    logic [63:0] nn;
    logic [31:0] e;
    if (n_in == 32'd0) return 32'd0;
    nn = {32'd0, n_in};
    r  = 64'd1 % nn;
    b  = {32'd0, c_in} % nn;
    e  = e_in;
    while (e != 32'd0) begin
      if (e[0]) r = (r * b) % nn;
      b = (b * b) % nn;
      e = e >> 1;
    end
    return r[31:0];
  endfunction

  // Driver: presents a request, records the expected result, returns just after the capture edge.
  task automatic drive_request(input logic [31:0] c_in, input logic [31:0] d_in, input logic [31:0] n_in);
    @(negedge clk);
    C       = c_in;
    d       = d_in;
    n       = n_in;
    compute = 1'b1;
    exp_q.push_back(model_modexp(c_in, d_in, n_in));
    exp_err_q.push_back(n_in == 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges after capture until decrypt_done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 4000; i++) begin
      @(posedge clk);
      #1;
      if (decrypt_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_request;
    @(negedge clk);
    compute = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset   = 1'b1;
    compute = 1'b1;
    C = 32'd2790; d = 32'd2753; n = 32'd3233;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state actual=%0d expected=%0d", state, ST_IDLE);
    end
    checks++;
    if (M !== 32'd0) begin
      failures++;
      $display("FAIL reset_m actual=%0d expected=0", M);
    end
    checks++;
    if (decrypt_done !== 1'b0 || decrypt_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags actual=%b%b expected=00", decrypt_done, decrypt_err);
    end
    @(negedge clk);
    reset   = 1'b0;
    compute = 1'b0;
  endtask

  task automatic test_vectors;
    logic [31:0] tc[12];
    logic [31:0] td[12];
    logic [31:0] tn[12];
    logic [31:0] exp_m;
    logic        exp_e;
    int          lat;
    tc[0] = 32'd2790; td[0] = 32'd2753;      tn[0] = 32'd3233;
    tc[1] = 32'd6023; td[1] = 32'd2753;      tn[1] = 32'd3233;
    tc[2] = 32'd5;    td[2] = 32'd0;         tn[2] = 32'd3233;
    tc[3] = 32'd7;    td[3] = 32'd9;         tn[3] = 32'd1;
    tc[4] = 32'd123;  td[4] = 32'd456;       tn[4] = 32'd0;
    tc[5] = 32'd2;    td[5] = 32'hFFFFFFFA;  tn[5] = 32'hFFFFFFFB;
    tc[6] = 32'd0;    td[6] = 32'd5;         tn[6] = 32'd3233;
    tc[7] = 32'd6466; td[7] = 32'd7;         tn[7] = 32'd3233;
    for (int i = 8; i < 12; i++) begin
      tc[i] = $urandom;
      td[i] = $urandom_range(32'hFFFF, 1);
      tn[i] = $urandom_range(32'hFFFFFFFF, 2);
    end
    for (int i = 0; i < 12; i++) begin
      drive_request(tc[i], td[i], tn[i]);
      C = $urandom; d = $urandom; n = $urandom;
      wait_done(lat);
      exp_m = exp_q.pop_front();
      exp_e = exp_err_q.pop_front();
      checks++;
      if (lat < 0) begin
        failures++;
        $display("FAIL vec%0d_timeout actual=no_done required=done", i);
      end else begin
        checks++;
        if (M !== exp_m) begin
          failures++;
          $display("FAIL vec%0d_m actual=%0d expected=%0d", i, M, exp_m);
        end
        checks++;
        if (decrypt_err !== exp_e) begin
          failures++;
          $display("FAIL vec%0d_err actual=%b expected=%b", i, decrypt_err, exp_e);
        end
        if (tn[i] == 32'd0) begin
          checks++;
          if (lat != 1) begin
            failures++;
            $display("FAIL vec%0d_nzero_latency actual=%0d expected=1", i, lat);
          end
        end
`ifdef RSA_DECRYPT_CONST_TIME_EN
        else begin
          checks++;
          if (lat != 2145) begin
            failures++;
            $display("FAIL vec%0d_const_latency actual=%0d expected=2145", i, lat);
          end
        end
`endif
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (decrypt_done !== 1'b1 || state !== ST_DONE) begin
        failures++;
        $display("FAIL vec%0d_hold actual=done%b_st%0d expected=done1_st%0d", i, decrypt_done, state, ST_DONE);
      end
      release_request;
      checks++;
      if (decrypt_done !== 1'b0 || state !== ST_IDLE) begin
        failures++;
        $display("FAIL vec%0d_release actual=done%b_st%0d expected=done0_st%0d", i, decrypt_done, state, ST_IDLE);
      end
      checks++;
      if (M !== exp_m) begin
        failures++;
        $display("FAIL vec%0d_m_held actual=%0d expected=%0d", i, M, exp_m);
      end
    end
  endtask

  task automatic test_compute_drop;
    logic [31:0] exp_m;
    logic        exp_e;
    int          lat;
    drive_request(32'd2790, 32'd2753, 32'd3233);
    repeat (50) @(posedge clk);
    @(negedge clk);
    compute = 1'b0;
    wait_done(lat);
    exp_m = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL drop_timeout actual=no_done required=done");
    end else begin
      checks++;
      if (M !== exp_m || decrypt_err !== exp_e) begin
        failures++;
        $display("FAIL drop_m actual=%0d/%b expected=%0d/%b", M, decrypt_err, exp_m, exp_e);
      end
      @(posedge clk);
      #1;
      checks++;
      if (decrypt_done !== 1'b0 || state !== ST_IDLE) begin
        failures++;
        $display("FAIL drop_one_cycle actual=done%b_st%0d expected=done0_st%0d", decrypt_done, state, ST_IDLE);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [31:0] exp_m;
    logic        exp_e;
    bit          seen;
    int          lat;
    drive_request(32'd2790, 32'd2753, 32'd3233);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (state == ST_MUL) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL abort_reach_mul actual=st%0d required=st%0d", state, ST_MUL);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    compute = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (state !== ST_IDLE || M !== 32'd0 || decrypt_done !== 1'b0 || decrypt_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset actual=st%0d_m%0d_%b%b expected=st%0d_m0_00",
               state, M, decrypt_done, decrypt_err, ST_IDLE);
    end
    exp_m = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    @(negedge clk);
    reset = 1'b0;
    drive_request(32'd2790, 32'd2753, 32'd3233);
    wait_done(lat);
    exp_m = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    checks++;
    if (lat < 0 || M !== exp_m || decrypt_err !== exp_e) begin
      failures++;
      $display("FAIL abort_rerun actual=%0d/%b lat=%0d expected=%0d/%b", M, decrypt_err, lat, exp_m, exp_e);
    end
    release_request;
  endtask

  initial begin
    reset   = 1'b1;
    compute = 1'b0;
    C = '0; d = '0; n = '0;
    test_reset();
    test_vectors();
    test_compute_drop();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_decrypt_sm.md
RSA_DECRYPT_SM -- requirements
Module: rsa_decrypt_sm

Interface
- REQ-001: The block SHALL have one parameter: WIDTH, default 32, operand width in bits; only 32 is supported.
- REQ-002: clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: reset  input  1  reset, synchronous, active-high.
- REQ-004: compute  input  1  level request; high in IDLE starts a decryption.
- REQ-005: C  input  32  ciphertext, unsigned, any value, including values >= n.
- REQ-006: d  input  32  private exponent, unsigned.
- REQ-007: n  input  32  modulus, unsigned.
- REQ-008: M  output  32  plaintext result C^d mod n.
- REQ-009: decrypt_done  output  1  result valid, held high until compute falls.
- REQ-010: decrypt_err  output  1  set with decrypt_done when n == 0.

Function
- REQ-011: The FSM SHALL have the states IDLE, REDUCE, MUL, SQR and DONE.
- REQ-012: In IDLE with compute=1, the block SHALL capture C, d and n into internal registers on that edge, clear decrypt_done and decrypt_err, and go to REDUCE; inputs SHALL be ignored after capture.
- REQ-013: If n==0, IDLE SHALL go straight to DONE with M=0 and decrypt_err=1.
- REQ-014: REDUCE SHALL compute base = C mod n by 32-cycle restoring division (one bit per cycle, 33-bit partial remainder), then initialise acc = 1 mod n (0 if n==1).
- REQ-015: Exponent bits SHALL be processed right-to-left. MUL: if the current d bit is 1, acc = acc*base mod n. SQR: base = base*base mod n; then shift the exponent right by 1.
- REQ-016: Each MUL/SQR SHALL use the sequential modular multiplier for exactly 33 cycles: 1 start cycle plus 32 interleaved shift-add iterations.
- REQ-017: Each multiplier iteration SHALL compute r = 2r + bit*a in 34 bits, then subtract n at most twice so that r < n; the multiplier operands are always < n.
- REQ-018: After SQR, the FSM SHALL go to DONE when all exponent bits are consumed (see Configuration for the termination rule); otherwise it SHALL go to MUL.
- REQ-019: On entry to DONE, M SHALL be loaded with acc and decrypt_done set to 1.
- REQ-020: DONE SHALL stay until compute==0, then go to IDLE on the next edge with decrypt_done=0; M SHALL hold its value until the next DONE.
- REQ-021: compute falling mid-operation SHALL be ignored; the operation completes, decrypt_done is high for one cycle, then the FSM returns to IDLE.
- REQ-022: d==0 SHALL give M = 1 mod n; C mod n == 0 with d>0 SHALL give M=0.

Reset
- REQ-023: While reset=1, the FSM SHALL be in IDLE and M, decrypt_done, decrypt_err and all datapath registers SHALL be 0.
- REQ-024: Reset SHALL abort any operation in progress within one cycle, including a multiply in flight; reset has priority over compute.

Configuration
- REQ-025: With RSA_DECRYPT_CONST_TIME_EN defined:
  - all 32 exponent bits are processed;
  - MUL always runs, with the result discarded when the bit is 0;
  - no early exit;
  - decrypt_done rises exactly 2145 cycles after the capture edge (32 REDUCE + 32x66 + 1), for every operand except n==0.
- REQ-026: Without RSA_DECRYPT_CONST_TIME_EN:
  - MUL is skipped when the exponent bit is 0;
  - the loop exits once the remaining exponent is 0, skipping the final SQR;
  - latency depends on the operands.

Structure
- REQ-027: Package rsa_pkg SHALL hold the WIDTH constant, the FSM state enum type and the multiplier iteration count (32).
- REQ-028: The modular multiplier SHALL be a sub-module rsa_modmul_seq, with ports start, a, b, n, done and result, instantiated once and shared by MUL and SQR.

Verification
- REQ-029: C=2790, d=2753, n=3233 -> M=65, decrypt_err=0.
- REQ-030: C=6023 (>= n), d=2753, n=3233 -> M=65.
- REQ-031: Edge operands:
  - C=5, d=0, n=3233 -> M=1.
  - C=7, d=9, n=1 -> M=0.
  - n=0 -> M=0, decrypt_err=1, done one cycle after capture.
- REQ-032: C=2, d=0xFFFFFFFA, n=0xFFFFFFFB -> M=1; under RSA_DECRYPT_CONST_TIME_EN, done exactly 2145 cycles after capture.
- REQ-033: reset asserted mid-MUL -> outputs 0, IDLE next cycle; the following request C=2790/d=2753/n=3233 -> 65.
- REQ-034: compute dropped mid-operation -> done high for exactly one cycle with M correct, then IDLE.
